tlb_op_sched: RTL
=================

TLB_OP_SCHED -- requirements
Module: tlb_op_sched

Interface
REQ-001 SHALL have parameter N_ENTRY, default 32, number of TLB entry pairs; index width 5.
REQ-002 SHALL have parameter FLUSH_EN, default 1, enables the hardware flush sweep.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  CPU TLB instruction request.
REQ-006 cmd_op  input  2  0=TLBWI, 1=TLBWR, 2=TLBP, 3=reserved (treated as no-op, completes).
REQ-007 cmd_index  input  5  CP0 Index for TLBWI.
REQ-008 cmd_ready  output  1  request accepted this cycle (valid & ready).
REQ-009 cmd_done  output  1  one-cycle pulse when the accepted command retires.
REQ-010 wired  input  5  CP0 Wired value.
REQ-011 wired_we  input  1  CP0 Wired being written this cycle.
REQ-012 flush_req  input  1  pulse; request invalidation of all non-wired entries.
REQ-013 flush_busy  output  1  flush sweep in progress or pending.
REQ-014 probe_match  input  1  OR of all header probeMatch lines.
REQ-015 probe_index  input  5  OR of all header probeIndex lines.
REQ-016 index_out  output  32  TLBP result: {~match,26'b0,index}; valid with cmd_done for TLBP.
REQ-017 random  output  5  CP0 Random value.
REQ-018 tlb_we  output  1  entry write strobe to TLB array.
REQ-019 tlb_windex  output  5  entry index for tlb_we.
REQ-020 tlb_winval  output  1  write invalid pattern instead of EntryHi/Lo (flush).
REQ-021 stall  output  1  pipeline stall; high from acceptance until cmd_done inclusive.

Function
REQ-022 FSM states SHALL be IDLE, PROBE_WAIT, PROBE_CAP, WRITE, FLUSH, DONE.
REQ-023 cmd_ready SHALL be high only in IDLE.
REQ-024 Accepted TLBWI/TLBWR SHALL go IDLE->WRITE->DONE: tlb_we high exactly one cycle in WRITE, cmd_done in DONE (latency 2).
REQ-025 TLBWI SHALL use cmd_index captured at acceptance; TLBWR SHALL use random captured at acceptance.
REQ-026 TLBP SHALL go IDLE->PROBE_WAIT->PROBE_CAP->DONE, sampling probe_match/probe_index in PROBE_CAP (one-cycle compare settle).
REQ-027 index_out SHALL hold the last TLBP result until the next TLBP retires.
REQ-028 random SHALL decrement once per cycle; when random==wired (or wired>=31) next value SHALL be 31.
REQ-029 wired_we SHALL force random to 31 next cycle, overriding decrement.
REQ-030 flush_req SHALL set a pending flag; the flag SHALL be taken only from IDLE with no cmd_valid (cmd has priority).
REQ-031 FLUSH SHALL write indices wired..31 ascending, one per cycle, tlb_winval=1, then return to IDLE; wired>31 ignored (wired is 5-bit, wired=0 sweeps 32 entries).
REQ-032 flush_req during FLUSH SHALL re-set pending, producing a second full sweep.
REQ-033 FLUSH is not stalling; cmd_valid during FLUSH SHALL wait (cmd_ready low).
REQ-034 FLUSH_EN=0 SHALL tie flush_busy low and ignore flush_req.
REQ-035 tlb_winval SHALL be 0 for TLBWI/TLBWR writes.

Reset
REQ-036 rst SHALL force state IDLE, random=31, index_out=0x80000000, flush pending cleared.
REQ-037 All outputs SHALL be 0 during/after reset except random=31, index_out as above.
REQ-038 rst mid-operation SHALL abort without issuing further tlb_we and without cmd_done.

Structure
REQ-039 Op encodings, state encoding and N_ENTRY/index width SHALL live in shared package tlb_pkg.
REQ-040 Random register logic SHALL be sub-module tlb_random (clk, rst, wired, wired_we, random).

Verification
REQ-041 TLBWI index 7 -> tlb_we one cycle, tlb_windex=7, winval=0, cmd_done 2 cycles after accept.
REQ-042 wired=4, free-run -> random sequence 31..4,31,...; wired_we -> random=31 next cycle.
REQ-043 TLBP with probe_match=1, probe_index=12 -> index_out=0x0000000C; match=0 -> 0x80000000.
REQ-044 wired=30, flush_req -> tlb_we at 30,31 with winval=1, flush_busy drops after.
REQ-045 flush_req and cmd_valid(TLBWR) same cycle -> TLBWR retires first, flush follows.
REQ-046 rst asserted in WRITE -> no tlb_we, no cmd_done, random=31.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0 TLB instruction scheduler.
// Holds the entry count, index width, op and state encodings, and the
// helper that formats a TLBP result into the CP0 Index register layout.
package tlb_pkg;

    localparam int TLB_N_ENTRY = 32;
    localparam int IDX_W       = 5;

    typedef enum logic [1:0] {
        OP_TLBWI = 2'd0,
        OP_TLBWR = 2'd1,
        OP_TLBP  = 2'd2,
        OP_RSVD  = 2'd3
    } tlbOpT;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PROBE_WAIT = 3'd1,
        ST_PROBE_CAP  = 3'd2,
        ST_WRITE      = 3'd3,
        ST_FLUSH      = 3'd4,
        ST_DONE       = 3'd5
    } tlbStateT;

    // CP0 Index layout: bit 31 is the probe-failure flag (set on miss).
    function automatic logic [31:0] probeResult(input logic match,
                                                input logic [IDX_W-1:0] idx);
        return {~match, 26'b0, idx};
    endfunction

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register.
// Counts down once per cycle from the top entry to Wired, then wraps back to
// the top entry. A write to Wired (or Wired at the top entry) pins it to the top.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (Random = top entry)
//   wired     : current CP0 Wired value
//   wired_we  : Wired is being written this cycle
//   random    : CP0 Random value
module tlb_random
    import tlb_pkg::*;
#(
    parameter int N_ENTRY = TLB_N_ENTRY
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N_ENTRY - 1);

    always_ff @(posedge clk) begin
        if (rst || wired_we) begin
            random <= TOP_IDX;
        end else if (random == wired || wired >= TOP_IDX) begin
            random <= TOP_IDX;
        end else begin
            random <= random - IDX_W'(1);
        end
    end

endmodule

// File: rtl/tlb_op_sched.sv
// TLB instruction scheduler.
// Sequences TLBWI/TLBWR/TLBP against the TLB array, stalls the pipeline while
// a command is in flight, and runs a background flush sweep that invalidates
// every non-wired entry. Commands always win over a pending flush.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_index: TLB instruction request (Index used by TLBWI)
//   cmd_ready                 : request accepted this cycle
//   cmd_done                  : one-cycle retire pulse
//   wired, wired_we           : CP0 Wired value and its write strobe
//   flush_req, flush_busy     : flush request pulse, sweep pending/in progress
//   probe_match, probe_index  : OR-reduced probe results from the TLB array
//   index_out                 : last TLBP result in CP0 Index format
//   random                    : CP0 Random
//   tlb_we/tlb_windex/tlb_winval : entry write strobe, index, invalidate select
//   stall                     : pipeline stall, acceptance through cmd_done
module tlb_op_sched
    import tlb_pkg::*;
#(
    parameter int N_ENTRY  = TLB_N_ENTRY,
    parameter int FLUSH_EN = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_index,
    output logic             cmd_ready,
    output logic             cmd_done,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_we,
    input  logic             flush_req,
    output logic             flush_busy,
    input  logic             probe_match,
    input  logic [IDX_W-1:0] probe_index,
    output logic [31:0]      index_out,
    output logic [IDX_W-1:0] random,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_windex,
    output logic             tlb_winval,
    output logic             stall
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRY - 1);
    localparam bit               FLUSH_ON = (FLUSH_EN != 0);

    tlbStateT         state;
    tlbStateT         stateNext;
    tlbOpT            op;
    logic             accept;
    logic             flushStart;
    logic             flushPend;
    logic [IDX_W-1:0] flushPtr;
    logic [IDX_W-1:0] cmdIdx;

    assign op = tlbOpT'(cmd_op);

    tlb_random #(
        .N_ENTRY (N_ENTRY)
    ) uRandom (
        .clk      (clk),
        .rst      (rst),
        .wired    (wired),
        .wired_we (wired_we),
        .random   (random)
    );

    // Next-state logic; a waiting command blocks the flush from starting.
    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        flushStart = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    case (op)
                        OP_TLBWI, OP_TLBWR: stateNext = ST_WRITE;
                        OP_TLBP:            stateNext = ST_PROBE_WAIT;
                        default:            stateNext = ST_DONE;
                    endcase
                end else if (flushPend) begin
                    flushStart = 1'b1;
                    stateNext  = ST_FLUSH;
                end
            end
            ST_PROBE_WAIT: stateNext = ST_PROBE_CAP;
            ST_PROBE_CAP:  stateNext = ST_DONE;
            ST_WRITE:      stateNext = ST_DONE;
            ST_DONE:       stateNext = ST_IDLE;
            ST_FLUSH: begin
                if (flushPtr == LAST_IDX) begin
                    stateNext = ST_IDLE;
                end
            end
            default:       stateNext = ST_IDLE;
        endcase
    end

    // Outputs are forced low while rst is high so an aborted operation
    // never leaks a write strobe or a retire pulse.
    always_comb begin
        cmd_ready  = 1'b0;
        cmd_done   = 1'b0;
        tlb_we     = 1'b0;
        tlb_windex = '0;
        tlb_winval = 1'b0;
        stall      = 1'b0;
        flush_busy = 1'b0;
        if (!rst) begin
            cmd_ready  = accept;
            cmd_done   = (state == ST_DONE);
            stall      = accept || (state == ST_PROBE_WAIT) || (state == ST_PROBE_CAP)
                      || (state == ST_WRITE) || (state == ST_DONE);
            flush_busy = FLUSH_ON && (flushPend || state == ST_FLUSH);
            if (state == ST_WRITE) begin
                tlb_we     = 1'b1;
                tlb_windex = cmdIdx;
            end else if (state == ST_FLUSH) begin
                tlb_we     = 1'b1;
                tlb_windex = flushPtr;
                tlb_winval = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A request arriving in the same cycle the flush starts stays pending,
    // which yields one more full sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            flushPend <= 1'b0;
        end else if (FLUSH_ON && flush_req) begin
            flushPend <= 1'b1;
        end else if (flushStart) begin
            flushPend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (flushStart) begin
            flushPtr <= wired;
        end else if (state == ST_FLUSH) begin
            flushPtr <= flushPtr + IDX_W'(1);
        end
    end

    // Write target is frozen at acceptance: Random keeps counting meanwhile.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmdIdx <= (op == OP_TLBWR) ? random : cmd_index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_out <= probeResult(1'b0, '0);
        end else if (state == ST_PROBE_CAP) begin
            index_out <= probeResult(probe_match, probe_index);
        end
    end

endmodule
